// File: rtl/theremin_pkg.sv
// Shared theremin types and constants used by the sensor, smoother and decoder.
package theremin_pkg;

    localparam int DIST_W = 16;
    localparam int MAX_MM = 4000;

    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } trk_state_e;

endpackage

// File: rtl/dist_window.sv
// Moving-average window: tap ring buffer plus a running sum of all taps.
module dist_window #(
    parameter int DIST_W   = 16,
    parameter int AVG_LOG2 = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         prime_i,
    input  logic                         push_i,
    input  logic [DIST_W-1:0]            dist_i,
    output logic [DIST_W+AVG_LOG2-1:0]   sum_o
);

    localparam int TAPS  = 1 << AVG_LOG2;
    localparam int SUM_W = DIST_W + AVG_LOG2;

    logic [DIST_W-1:0]   tap_q [TAPS];
    logic [AVG_LOG2-1:0] wr_ptr_q;
    logic [SUM_W-1:0]    sum_q;

    // Priming fills every tap so the average is exact from the first output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) tap_q[i] <= '0;
            wr_ptr_q <= '0;
            sum_q    <= '0;
        end else if (prime_i) begin
            for (int i = 0; i < TAPS; i++) tap_q[i] <= dist_i;
            sum_q <= SUM_W'(dist_i) << AVG_LOG2;
        end else if (push_i) begin
            tap_q[wr_ptr_q] <= dist_i;
            sum_q           <= sum_q + SUM_W'(dist_i) - SUM_W'(tap_q[wr_ptr_q]);
            wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/dist_smoother.sv
// Ultrasonic distance conditioner: range/outlier rejection, 8-tap average, range flag.
module dist_smoother
    import theremin_pkg::*;
#(
    parameter int DIST_W       = theremin_pkg::DIST_W,
    parameter int AVG_LOG2     = 3,
    parameter int MAX_MM       = theremin_pkg::MAX_MM,
    parameter int JUMP_MM      = 300,
    parameter int REJECT_LIMIT = 3,
    parameter int MISS_LIMIT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DIST_W-1:0] in_dist,
    output logic              out_valid,
    output logic [DIST_W-1:0] out_dist,
    output logic              in_range
);

    localparam int SUM_W = DIST_W + AVG_LOG2;
    localparam int RC_W  = $clog2(REJECT_LIMIT + 1);
    localparam int MC_W  = $clog2(MISS_LIMIT + 1);

    function automatic logic [DIST_W:0] abs_diff(input logic [DIST_W-1:0] a,
                                                 input logic [DIST_W-1:0] b);
        logic signed [DIST_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

    logic              vld_p0_q;
    logic [DIST_W-1:0] dist_p0_q;
    trk_state_e        state_q, state_d;
    logic [RC_W-1:0]   reject_cnt_q, reject_cnt_d;
    logic [MC_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic              prime_d, push_d, drop_d;
    logic              vld_p1_q;
    logic              out_valid_q, in_range_q;
    logic [DIST_W-1:0] out_dist_q;
    logic [SUM_W-1:0]  win_sum;
    logic              oor, outlier;

    // Stage p0: capture the raw sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0_q  <= 1'b0;
            dist_p0_q <= '0;
        end else begin
            vld_p0_q  <= in_valid;
            dist_p0_q <= in_dist;
        end
    end

    // Outlier test deliberately uses the published average, even with an update in flight.
    assign oor     = (dist_p0_q == '0) || (dist_p0_q > DIST_W'(MAX_MM));
    assign outlier = abs_diff(dist_p0_q, out_dist_q) > (DIST_W + 1)'(JUMP_MM);

    always_comb begin
        state_d      = state_q;
        reject_cnt_d = reject_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        prime_d      = 1'b0;
        push_d       = 1'b0;
        drop_d       = 1'b0;
        if (vld_p0_q) begin
            case (state_q)
                EMPTY: begin
                    if (!oor) begin
                        prime_d = 1'b1;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (oor) begin
                        if (miss_cnt_q == MC_W'(MISS_LIMIT - 1)) begin
                            state_d      = EMPTY;
                            reject_cnt_d = '0;
                            miss_cnt_d   = '0;
                            drop_d       = 1'b1;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end else if (outlier) begin
                        if (reject_cnt_q == RC_W'(REJECT_LIMIT - 1)) begin
                            prime_d      = 1'b1;
                            reject_cnt_d = '0;
                        end else begin
                            reject_cnt_d = reject_cnt_q + 1'b1;
                        end
                    end else begin
                        push_d       = 1'b1;
                        reject_cnt_d = '0;
                        miss_cnt_d   = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Stage p1: tracking state, window update and range flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= EMPTY;
            reject_cnt_q <= '0;
            miss_cnt_q   <= '0;
            vld_p1_q     <= 1'b0;
            in_range_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_dist_q   <= '0;
        end else begin
            state_q      <= state_d;
            reject_cnt_q <= reject_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            vld_p1_q     <= prime_d | push_d;
            out_valid_q  <= vld_p1_q;
            if (vld_p1_q) out_dist_q <= DIST_W'(win_sum >> AVG_LOG2);
            if (drop_d) in_range_q <= 1'b0;
            else if (vld_p1_q) in_range_q <= 1'b1;
        end
    end

    dist_window #(
        .DIST_W   (DIST_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_window (
        .clk     (clk),
        .reset   (reset),
        .prime_i (prime_d),
        .push_i  (push_d),
        .dist_i  (dist_p0_q),
        .sum_o   (win_sum)
    );

    assign out_valid = out_valid_q;
    assign out_dist  = out_dist_q;
    assign in_range  = in_range_q;

endmodule

// File: tb/tb_dist_smoother.sv
// Bench for dist_smoother: transaction-level reference model checked every cycle plus directed literals.
module tb_dist_smoother;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_dist;
    logic        out_valid;
    logic [15:0] out_dist;
    logic        in_range;

    always #5 clk = ~clk;

    dist_smoother dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_dist   (in_dist),
        .out_valid (out_valid),
        .out_dist  (out_dist),
        .in_range  (in_range)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Reference model: sample-by-sample rules, results published after a fixed delay.
    typedef struct {
        int due;
        bit drop;
        int val;
    } ev_t;

    ev_t evq[$];
    int  m_taps[8];
    int  m_ptr  = 0;
    bit  m_trk  = 0;
    int  m_rej  = 0;
    int  m_miss = 0;
    int  m_out  = 0;
    bit  m_vld  = 0;
    bit  m_rng  = 0;
    int  cyc    = 0;
    int  in_cyc = 0;
    int  pulse_cyc = 0;
    int  seen[$];

    function automatic int m_avg();
        int s = 0;
        foreach (m_taps[i]) s += m_taps[i];
        return s / 8;
    endfunction

    function automatic void m_fill(int d);
        foreach (m_taps[i]) m_taps[i] = d;
    endfunction

    function automatic void m_publish();
        ev_t e;
        e.due = cyc + 2; e.drop = 1'b0; e.val = m_avg();
        evq.push_back(e);
    endfunction

    function automatic void m_step(int d);
        bit oor;
        int dev;
        ev_t e;
        oor = (d == 0) || (d > 4000);
        dev = d - m_out;
        if (dev < 0) dev = -dev;
        if (!m_trk) begin
            if (!oor) begin
                m_fill(d);
                m_trk = 1'b1;
                m_publish();
            end
        end else if (oor) begin
            m_miss++;
            if (m_miss == 4) begin
                m_trk = 1'b0; m_rej = 0; m_miss = 0;
                e.due = cyc + 1; e.drop = 1'b1; e.val = 0;
                evq.push_back(e);
            end
        end else if (dev > 300) begin
            m_rej++;
            if (m_rej == 3) begin
                m_fill(d);
                m_rej = 0;
                m_publish();
            end
        end else begin
            m_taps[m_ptr] = d;
            m_ptr = (m_ptr + 1) % 8;
            m_rej = 0; m_miss = 0;
            m_publish();
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            evq.delete();
            m_fill(0);
            m_ptr = 0; m_trk = 0; m_rej = 0; m_miss = 0;
            m_out = 0; m_vld = 0; m_rng = 0;
        end else begin
            m_vld = 0;
            foreach (evq[i]) if (evq[i].due == cyc && !evq[i].drop) begin
                m_vld = 1; m_out = evq[i].val; m_rng = 1;
            end
            foreach (evq[i]) if (evq[i].due == cyc && evq[i].drop) m_rng = 0;
            for (int i = evq.size() - 1; i >= 0; i--) if (evq[i].due == cyc) evq.delete(i);
            if (in_valid) begin
                in_cyc = cyc;
                m_step(int'(in_dist));
            end
        end
        #1;
        chk("cyc_out_valid", int'(out_valid), int'(m_vld));
        chk("cyc_out_dist", int'(out_dist), m_out);
        chk("cyc_in_range", int'(in_range), int'(m_rng));
        if (out_valid) begin
            seen.push_back(int'(out_dist));
            pulse_cyc = cyc;
        end
    end

    function automatic int seen_at(int i);
        if (i < seen.size()) return seen[i];
        return -1;
    endfunction

    task automatic send(input int d);
        @(negedge clk);
        in_valid = 1'b1;
        in_dist  = 16'(d);
        @(negedge clk);
        in_valid = 1'b0;
        in_dist  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drop_track();
        repeat (4) begin
            send(0);
            idle(1);
        end
        idle(2);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_dist  = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_dist", int'(out_dist), 0);
        chk("rst_in_range", int'(in_range), 0);
        reset = 1'b1;
        idle(2);

        // single sample primes the window
        seen.delete();
        send(500);
        idle(4);
        chk("s1_pulses", seen.size(), 1);
        chk("s1_value", seen_at(0), 500);
        chk("s1_latency", pulse_cyc - in_cyc, 2);
        chk("s1_in_range", int'(in_range), 1);

        // eight good samples walk the average up in steps of 10
        seen.delete();
        repeat (8) begin
            send(580);
            idle(2);
        end
        chk("s2_pulses", seen.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("s2_value%0d", i), seen_at(i), 510 + 10 * i);

        // single outlier rejected, three in a row re-prime
        drop_track();
        chk("drop_in_range", int'(in_range), 0);
        chk("drop_hold", int'(out_dist), 580);
        send(500);
        idle(4);
        seen.delete();
        send(1200);
        idle(3);
        chk("s3_reject", seen.size(), 0);
        send(510);
        idle(3);
        chk("s3_accept", seen_at(0), 501);
        repeat (3) begin
            send(1200);
            idle(2);
        end
        idle(2);
        chk("s3_pulses", seen.size(), 2);
        chk("s3_reprime", seen_at(1), 1200);

        // misses hold the output until the fourth drops tracking
        drop_track();
        send(500);
        idle(4);
        seen.delete();
        send(0);    idle(2);
        send(5000); idle(2);
        send(0);    idle(2);
        chk("s4_no_pulse", seen.size(), 0);
        chk("s4_hold", int'(out_dist), 500);
        chk("s4_still_range", int'(in_range), 1);
        send(0);
        idle(3);
        chk("s4_lost", int'(in_range), 0);
        send(800);
        idle(4);
        chk("s4_reacquire", seen_at(0), 800);
        chk("s4_range_back", int'(in_range), 1);

        // back-to-back samples with no stall
        drop_track();
        send(1000);
        idle(4);
        seen.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_dist  = 16'd1008;
        idle(7);
        @(negedge clk);
        in_valid = 1'b0;
        in_dist  = '0;
        idle(4);
        chk("s5_pulses", seen.size(), 8);
        chk("s5_first", seen_at(0), 1001);
        chk("s5_last", seen_at(7), 1008);

        // reset while a sample is in flight
        seen.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_dist  = 16'd900;
        @(negedge clk);
        in_valid = 1'b0;
        in_dist  = '0;
        reset    = 1'b0;
        idle(2);
        chk("s6_out_valid", int'(out_valid), 0);
        chk("s6_out_dist", int'(out_dist), 0);
        chk("s6_in_range", int'(in_range), 0);
        reset = 1'b1;
        idle(4);
        chk("s6_no_pulse", seen.size(), 0);
        send(500);
        idle(4);
        chk("s6_empty_prime", seen_at(0), 500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dist_smoother.md
# dist_smoother

Conditions raw ultrasonic distance samples (mm) between the echo-ranging sensor and the distance-to-frequency decoder. It rejects out-of-range readings and single-shot outliers. It maintains an 8-tap moving average, so the tone and the display stop jittering. It also raises a range flag that the top level uses to mute the PWM audio output.

## Interface
- `DIST_W`, 16: width of distance samples in mm
- `AVG_LOG2`, 3: log2 of averaging depth (8 taps)
- `MAX_MM`, 4000: largest valid distance; samples of 0 or above this are out-of-range
- `JUMP_MM`, 300: maximum accepted deviation from the current average
- `REJECT_LIMIT`, 3: number of consecutive outliers that forces a re-prime
- `MISS_LIMIT`, 4: number of consecutive out-of-range samples that drops tracking
- `clk` in 1: system clock (100 MHz)
- `reset` in 1: asynchronous, active-low reset
- `in_valid` in 1: one-cycle strobe; `in_dist` is a new sample
- `in_dist` in DIST_W: raw distance, mm
- `out_valid` out 1: one-cycle strobe; `out_dist` was updated
- `out_dist` out DIST_W: averaged distance, mm, held between updates
- `in_range` out 1: 1 while tracking a valid target

## Operation
- States: EMPTY and TRACK.
- Classify every `in_valid` sample:
  - **out-of-range**: `in_dist == 0` or `in_dist > MAX_MM`
  - **outlier**: in TRACK only, when `|in_dist - out_dist| > JUMP_MM`
  - **good**: anything else
- **EMPTY**:
  - Good sample → prime: all 2^AVG_LOG2 taps := x, sum := x << AVG_LOG2, go to TRACK.
  - Out-of-range sample → ignored.
- **TRACK, good sample**:
  - Write the sample at `wr_ptr`; sum := sum + x − tap[wr_ptr]; `wr_ptr` += 1 (wraps modulo 2^AVG_LOG2).
  - Clear `reject_cnt` and `miss_cnt`.
- **TRACK, outlier**:
  - `reject_cnt` += 1, no output.
  - When the count reaches `REJECT_LIMIT`, prime with this sample (a genuine hand move) and clear `reject_cnt`.
- **TRACK, out-of-range**:
  - `miss_cnt` += 1; `reject_cnt` unchanged.
  - When `miss_cnt` reaches `MISS_LIMIT`: go to EMPTY, `in_range` := 0, clear counters. `out_dist` holds its last value.
- **Output**:
  - `out_dist` := sum >> AVG_LOG2 (truncating).
  - After every prime or update, `in_range` := 1 and `out_valid` pulses.
- **Width**: sum is DIST_W + AVG_LOG2 bits and never overflows. The abs-difference is computed at DIST_W + 1 bits.

## Timing
- Reset values: `out_valid` 0, `out_dist` 0, `in_range` 0, state EMPTY, sum 0, all taps 0, `wr_ptr` 0, all counters 0.
- Latency: `in_valid` sampled at edge N → taps and sum update at edge N+1 → `out_dist` and `out_valid` at edge N+2. This holds for both prime and update.
- Fully pipelined: `in_valid` on back-to-back cycles is accepted every cycle with no stall. The outlier compare uses the current registered `out_dist`, even when an update is still in flight.
- `out_valid` is high for exactly one cycle per accepted or primed sample. It never fires for rejected or ignored samples.
- `in_range` falls at edge N+1 after the `MISS_LIMIT`-th miss.
- Reset assertion mid-pipeline discards everything in flight. The first `in_valid` after deassertion is handled as EMPTY.

## Structure
- `theremin_pkg` holds `DIST_W`, `MAX_MM`, and the state enum (EMPTY, TRACK), shared with the sensor and decoder.
- One sub-module, `dist_window`:
  - tap register array, `wr_ptr`, and running sum
  - controls: prime and push
- `dist_smoother` owns the classification, counters, FSM and output register.

## Test plan
- Reset, then a single sample `in_dist`=500 → `out_valid` at N+2, `out_dist`=500, `in_range`=1.
- Prime at 500, then eight good samples of 580 → the `out_dist` sequence 510, 520, …, 580, each with an `out_valid` pulse.
- Tracking at 500, one sample of 1200 and then 510 → the 1200 produces no `out_valid`; the 510 gives `out_dist`=501. Then three consecutive samples of 1200 → re-prime with `out_dist`=1200.
- Tracking at 500, samples 0, 5000, 0 → `out_dist` stays 500, `in_range`=1. A fourth miss → `in_range`=0. The next sample of 800 → `out_dist`=800.
- `in_valid` high for 8 consecutive cycles after a prime at 1000, each sample 1008 → 8 `out_valid` pulses; the final `out_dist`=1008.
- Assert `reset` one cycle after a good `in_valid` → no `out_valid`, and all outputs read 0.
